// File: rtl/eth_rx_pkg.sv
// Shared constants and types for the Ethernet receive path.
// The reflected CRC polynomial is derived here so every CRC user agrees on it.
package eth_rx_pkg;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  // Depth of the FCS-stripping delay line: 4 FCS bytes plus one held beat.
  localparam int unsigned DLY_BYTES = 5;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} rx_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } axis_beat_t;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  localparam logic [31:0] CRC32_POLY_REFL = reflect32(CRC32_POLY);

endpackage

// File: rtl/crc32_d8.sv
// Combinational one-byte update of a reflected CRC-32 (LSB-first bit order).
// No final inversion: callers either compare against the residue or invert themselves.
module crc32_d8
  import eth_rx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h000000, data_in};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_rx_frame_checker.sv
// GMII-style receive front end: strips preamble/SFD and FCS, checks CRC and length,
// and emits each frame as an 8-bit AXI-Stream packet with tuser marking bad frames.
module eth_rx_frame_checker
  import eth_rx_pkg::*;
#(
  parameter int unsigned MIN_FRAME_BYTES = 64,
  parameter int unsigned MAX_FRAME_BYTES = 1518
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_dv,
  input  logic       i_rx_er,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  input  logic       m_axis_trdy,
  output logic       o_frame_good,
  output logic       o_frame_bad,
  output logic       o_overflow
);

  localparam int unsigned     CNT_W   = 11;
  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_FRAME_BYTES);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_FRAME_BYTES);
  localparam logic [2:0]       FULL    = 3'(DLY_BYTES);

  rx_state_e                     state_q, state_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic [31:0]                   crc_q, crc_d, crc_next;
  logic [DLY_BYTES-1:0][7:0]     line_q, line_d;
  logic [2:0]                    fill_q, fill_d;
  logic                          err_q, err_d;
  logic                          emitted_q, emitted_d;
  axis_beat_t                    beat_q, beat_d;
  logic                          tvalid_q, tvalid_d;
  logic                          good_q, good_d;
  logic                          bad_q, bad_d;
  logic                          ovf_q, ovf_d;

  logic       accept, stalled, full, frame_bad;
  logic       due, abort;
  axis_beat_t due_beat;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data_in (i_rx_data),
    .crc_out (crc_next)
  );

  assign accept    = tvalid_q & m_axis_trdy;
  assign stalled   = tvalid_q & ~m_axis_trdy;
  assign full      = (fill_q == FULL);
  assign frame_bad = (crc_q != CRC32_RESIDUE) | (count_q < MIN_CNT) | err_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    crc_d     = crc_q;
    line_d    = line_q;
    fill_d    = fill_q;
    err_d     = err_q;
    emitted_d = emitted_q;
    beat_d    = beat_q;
    tvalid_d  = tvalid_q & ~accept;
    good_d    = accept & beat_q.last & ~beat_q.user;
    bad_d     = accept & beat_q.last & beat_q.user;
    ovf_d     = 1'b0;
    due       = 1'b0;
    abort     = 1'b0;
    due_beat  = '0;

    unique case (state_q)
      IDLE: begin
        if (i_rx_dv) begin
          state_d = (i_rx_data == ETH_PREAMBLE) ? PREAMBLE : DROP;
        end
      end
      PREAMBLE: begin
        if (!i_rx_dv) begin
          state_d = IDLE;
        end else if (i_rx_data == ETH_SFD) begin
          state_d   = DATA;
          crc_d     = CRC32_INIT;
          count_d   = '0;
          fill_d    = '0;
          err_d     = 1'b0;
          emitted_d = 1'b0;
        end else if (i_rx_data != ETH_PREAMBLE) begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (i_rx_dv) begin
          crc_d   = crc_next;
          count_d = (count_q == CNT_SAT) ? count_q : count_q + 1'b1;
          line_d  = {i_rx_data, line_q[DLY_BYTES-1:1]};
          err_d   = err_q | i_rx_er;
          if (!full) begin
            fill_d = fill_q + 3'd1;
          end
          if (count_q == MAX_CNT) begin
            // This byte would exceed the maximum: close the packet as bad and abort.
            abort    = 1'b1;
            due      = full;
            due_beat = '{data: line_q[0], last: 1'b1, user: 1'b1};
          end else if (full) begin
            due      = 1'b1;
            due_beat = '{data: line_q[0], last: 1'b0, user: 1'b0};
          end
        end else begin
          state_d = IDLE;
          if (full) begin
            due      = 1'b1;
            due_beat = '{data: line_q[0], last: 1'b1, user: frame_bad};
          end else if (emitted_q) begin
            due      = 1'b1;
            due_beat = '{data: 8'h00, last: 1'b1, user: 1'b1};
          end
        end
      end
      DROP: begin
        if (!i_rx_dv) begin
          state_d = IDLE;
        end
      end
      default: state_d = DROP;
    endcase

    if (due && !stalled) begin
      beat_d    = due_beat;
      tvalid_d  = 1'b1;
      emitted_d = 1'b1;
    end
    if ((due && stalled) || abort) begin
      ovf_d   = 1'b1;
      state_d = DROP;
      // A stalled beat of this frame is closed in place; a stalled tlast of the
      // previous frame is left untouched and the new frame vanishes.
      if (stalled && emitted_q) begin
        beat_d.last = 1'b1;
        beat_d.user = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= DROP;
      count_q   <= '0;
      crc_q     <= CRC32_INIT;
      line_q    <= '0;
      fill_q    <= '0;
      err_q     <= 1'b0;
      emitted_q <= 1'b0;
      beat_q    <= '0;
      tvalid_q  <= 1'b0;
      good_q    <= 1'b0;
      bad_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      crc_q     <= crc_d;
      line_q    <= line_d;
      fill_q    <= fill_d;
      err_q     <= err_d;
      emitted_q <= emitted_d;
      beat_q    <= beat_d;
      tvalid_q  <= tvalid_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      ovf_q     <= ovf_d;
    end
  end

  assign m_axis_tdata  = beat_q.data;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = beat_q.last;
  assign m_axis_tuser  = beat_q.user;
  assign o_frame_good  = good_q;
  assign o_frame_bad   = bad_q;
  assign o_overflow    = ovf_q;

endmodule

// File: tb/tb_eth_rx_frame_checker.sv
// Directed and randomized frames against a frame-level reference model: expected beats
// are the frame minus its FCS, with tuser from FCS match, minimum length and rx_er.
module tb_eth_rx_frame_checker;

  localparam int MIN_LEN = 64;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_rx_dv = 1'b0;
  logic       i_rx_er = 1'b0;
  logic       m_axis_trdy = 1'b1;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic       o_frame_good, o_frame_bad, o_overflow;

  eth_rx_frame_checker dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_rx_data     (i_rx_data),
    .i_rx_dv       (i_rx_dv),
    .i_rx_er       (i_rx_er),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_trdy   (m_axis_trdy),
    .o_frame_good  (o_frame_good),
    .o_frame_bad   (o_frame_bad),
    .o_overflow    (o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } tb_beat_t;

  tb_beat_t   got[$];
  int         n_good = 0, n_bad = 0, n_ovf = 0;
  int         nvec = 0, nerr = 0;
  logic [7:0] frm[$];
  int         base_n, g0, b0, o0;

  // Monitor: a beat counts as transferred when tvalid and trdy are both high mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (m_axis_tvalid && m_axis_trdy) begin
        got.push_back(tb_beat_t'({m_axis_tdata, m_axis_tlast, m_axis_tuser}));
      end
      n_good += int'(o_frame_good);
      n_bad  += int'(o_frame_bad);
      n_ovf  += int'(o_overflow);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic [7:0] d, input logic er);
    i_rx_dv   = dv;
    i_rx_data = d;
    i_rx_er   = er;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic mark();
    base_n = got.size();
    g0     = n_good;
    b0     = n_bad;
    o0     = n_ovf;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    check({tag, "_tdata"},  32'(m_axis_tdata),  32'd0);
    check({tag, "_tlast"},  32'(m_axis_tlast),  32'd0);
    check({tag, "_tuser"},  32'(m_axis_tuser),  32'd0);
    check({tag, "_good"},   32'(o_frame_good),  32'd0);
    check({tag, "_bad"},    32'(o_frame_bad),   32'd0);
    check({tag, "_ovf"},    32'(o_overflow),    32'd0);
  endtask

  // Ethernet FCS over frm[0..n-1], bit-serial LFSR form, already inverted.
  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    logic        fb;
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ frm[k][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  // kind: 0 incrementing payload, 1 random payload; a frame of len<4 gets no FCS.
  task automatic build(input int len, input int kind, input logic corrupt);
    logic [31:0] f;
    frm.delete();
    for (int k = 0; k < ((len >= 4) ? len - 4 : len); k++) begin
      frm.push_back((kind == 0) ? 8'(k) : 8'($urandom));
    end
    if (len >= 4) begin
      f = fcs_of(len - 4);
      frm.push_back(f[7:0]);
      frm.push_back(f[15:8]);
      frm.push_back(f[23:16]);
      frm.push_back(f[31:24] ^ {7'd0, corrupt});
    end
  endtask

  task automatic send(input int er_idx, input int rdy_off, input int rst_idx);
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < frm.size(); i++) begin
      if (i == rdy_off) m_axis_trdy = 1'b0;
      if (rst_idx >= 0 && i == rst_idx) begin
        reset_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
      end
      if (rst_idx >= 0 && i == rst_idx + 2) reset_n = 1'b1;
      drive(1'b1, frm[i], i == er_idx);
    end
    drive(1'b0, 8'h00, 1'b0);
    if (rdy_off == frm.size()) m_axis_trdy = 1'b0;
    idle(11);
  endtask

  task automatic expect_beats(input string tag, input int nb, input logic user);
    int e0 = nerr;
    check({tag, "_count"}, 32'(got.size() - base_n), 32'(nb));
    for (int i = 0; i < nb && base_n + i < got.size() && nerr - e0 < 4; i++) begin
      check({tag, "_beat"}, 32'(got[base_n + i]),
            32'({frm[i], i == nb - 1, (i == nb - 1) ? user : 1'b0}));
    end
  endtask

  // Reference model for a frame sent with trdy held high throughout.
  task automatic check_frame(input string tag, input logic er);
    int   len = frm.size();
    int   nb  = (len >= 5) ? len - 4 : 0;
    logic ok  = (len >= 4) &&
                ({frm[len-1], frm[len-2], frm[len-3], frm[len-4]} == fcs_of(len - 4));
    logic usr = !ok || (len < MIN_LEN) || er;
    expect_beats(tag, nb, usr);
    check({tag, "_good"}, 32'(n_good - g0), 32'((nb > 0 && !usr) ? 1 : 0));
    check({tag, "_bad"},  32'(n_bad - b0),  32'((nb > 0 && usr) ? 1 : 0));
    check({tag, "_ovf"},  32'(n_ovf - o0),  32'd0);
  endtask

  initial begin
    idle(3);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    idle(3);
    check_outputs_zero("idle");

    build(64, 0, 1'b0); mark(); send(-1, -1, -1); check_frame("good64", 1'b0);
    build(64, 0, 1'b1); mark(); send(-1, -1, -1); check_frame("badfcs", 1'b0);
    build(40, 0, 1'b0); mark(); send(-1, -1, -1); check_frame("runt40", 1'b0);
    build(64, 1, 1'b0); mark(); send(10, -1, -1); check_frame("rxer", 1'b1);
    build(63, 1, 1'b0); mark(); send(-1, -1, -1); check_frame("len63", 1'b0);
    build(5, 1, 1'b0);  mark(); send(-1, -1, -1); check_frame("len5", 1'b0);
    build(4, 1, 1'b0);  mark(); send(-1, -1, -1); check_frame("len4", 1'b0);
    build(1518, 1, 1'b0); mark(); send(-1, -1, -1); check_frame("max", 1'b0);

    // One byte beyond the maximum length aborts the frame as bad.
    build(1600, 1, 1'b0); mark(); send(-1, -1, -1);
    expect_beats("abort", 1514, 1'b1);
    check("abort_ovf", 32'(n_ovf - o0), 32'd1);
    check("abort_bad", 32'(n_bad - b0), 32'd1);

    // Backpressure from byte 20: pending beat 14 is closed as bad.
    build(64, 1, 1'b0); mark(); send(-1, 20, -1);
    check("bp_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("bp_tdata",  32'(m_axis_tdata),  32'(frm[14]));
    check("bp_tlast",  32'(m_axis_tlast),  32'd1);
    check("bp_tuser",  32'(m_axis_tuser),  32'd1);
    check("bp_ovf",    32'(n_ovf - o0),    32'd1);
    m_axis_trdy = 1'b1;
    idle(3);
    expect_beats("bp", 15, 1'b1);
    check("bp_bad",  32'(n_bad - b0),  32'd1);
    check("bp_good", 32'(n_good - g0), 32'd0);
    build(64, 1, 1'b0); mark(); send(-1, -1, -1); check_frame("after_bp", 1'b0);

    // Previous tlast stalled when the next frame needs its first beat.
    build(64, 1, 1'b0); mark();
    send(-1, 64, -1);
    send(-1, -1, -1);
    check("bnd_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("bnd_tlast",  32'(m_axis_tlast),  32'd1);
    check("bnd_tuser",  32'(m_axis_tuser),  32'd0);
    check("bnd_ovf",    32'(n_ovf - o0),    32'd1);
    m_axis_trdy = 1'b1;
    idle(3);
    expect_beats("bnd", 60, 1'b0);
    check("bnd_good", 32'(n_good - g0), 32'd1);
    check("bnd_bad",  32'(n_bad - b0),  32'd0);

    // Reset mid-frame at byte 30: remainder of that frame produces nothing.
    build(64, 1, 1'b0); send(-1, -1, 30);
    mark();
    idle(2);
    check("rst_beats", 32'(got.size() - base_n), 32'd0);
    build(64, 0, 1'b0); mark(); send(-1, -1, -1); check_frame("after_rst", 1'b0);

    for (int t = 0; t < 10; t++) begin
      int len = (t < 2) ? int'($urandom_range(1, 6)) : int'($urandom_range(20, 150));
      int er  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 19)) : -1;
      er = (er >= len) ? -1 : er;
      build(len, 1, 1'($urandom_range(0, 2) == 0));
      mark();
      send(er, -1, -1);
      check_frame("rand", 1'(er >= 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
